// File: rtl/game_level_if.sv
// -----------------------------------------------------------------------------
// game_level_if
// Bundles the game-controller bus: gameplay inputs coming from the
// input/collision logic and the progress/status outputs consumed by the
// VGA/scoreboard logic.
//   master : drives Start, Ack, Pause, Hit, Enemies_Clear, Key_Held;
//            observes Level, Lives_Left, Level_Up, Invuln, q_* flags
//   slave  : the controller side (game_level_ctrl)
// -----------------------------------------------------------------------------
interface game_level_if #(
   parameter int LVL_W   = 3,
   parameter int LIVES_W = 2
);
   logic               Start;
   logic               Ack;
   logic               Pause;
   logic               Hit;
   logic               Enemies_Clear;
   logic               Key_Held;
   logic [LVL_W-1:0]   Level;
   logic [LIVES_W-1:0] Lives_Left;
   logic               Level_Up;
   logic               Invuln;
   logic               q_Idle;
   logic               q_Play;
   logic               q_Pause;
   logic               q_Over;
   logic               q_Win;

   modport master (
      output Start, Ack, Pause, Hit, Enemies_Clear, Key_Held,
      input  Level, Lives_Left, Level_Up, Invuln,
      input  q_Idle, q_Play, q_Pause, q_Over, q_Win
   );

   modport slave (
      input  Start, Ack, Pause, Hit, Enemies_Clear, Key_Held,
      output Level, Lives_Left, Level_Up, Invuln,
      output q_Idle, q_Play, q_Pause, q_Over, q_Win
   );
endinterface

// File: rtl/game_level_ctrl.sv
// -----------------------------------------------------------------------------
// game_level_ctrl
// Game-progression controller: walks the player through NUM_LEVELS levels,
// keeps the lives counter, handles pause, per-level key requirements,
// post-hit invulnerability and clear-arming.
// Ports:
//   Clk   - system clock
//   Reset - asynchronous, active-high reset
//   bus   - game_level_if.slave: Start/Ack/Pause/Hit/Enemies_Clear/Key_Held
//           in; Level/Lives_Left/Level_Up/Invuln and one-hot q_* flags out
//           (all outputs registered)
// -----------------------------------------------------------------------------
module game_level_ctrl #(
   parameter int         NUM_LEVELS    = 4,
   parameter int         LVL_W         = 3,
   parameter int         LIVES_INIT    = 3,
   parameter int         LIVES_W       = 2,
   parameter logic [7:0] KEY_MASK      = 8'b0000_0100,
   parameter int         INVULN_CYCLES = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   game_level_if.slave bus
);

   localparam int INV_W = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PLAY  = 3'd1,
      S_PAUSE = 3'd2,
      S_OVER  = 3'd3,
      S_WIN   = 3'd4
   } state_t;

   state_t             state_r,    state_s;
   logic [LVL_W-1:0]   level_r,    level_s;
   logic [LIVES_W-1:0] lives_r,    lives_s;
   logic [INV_W-1:0]   inv_cnt_r,  inv_cnt_s;
   logic               armed_r,    armed_s;
   logic               level_up_r, level_up_s;
   logic               invuln_r;
   logic               q_idle_r, q_play_r, q_pause_r, q_over_r, q_win_r;
   logic               hit_ok_s;
   logic               clear_s;
   logic               last_level_s;

   // Key requirement for a level; mask bits at or above NUM_LEVELS never apply.
   function automatic logic key_needed(input logic [LVL_W-1:0] lvl);
      logic need;
      need = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if ((i < NUM_LEVELS) && (int'(lvl) == i)) begin
            need = KEY_MASK[i];
         end
      end
      return need;
   endfunction

   assign hit_ok_s     = bus.Hit & ~invuln_r;
   assign clear_s      = armed_r & bus.Enemies_Clear &
                         (~key_needed(level_r) | bus.Key_Held);
   assign last_level_s = (int'(level_r) >= (NUM_LEVELS - 1));

   // Next-state and next-value logic for the whole controller.
   always_comb begin
      state_s    = state_r;
      level_s    = level_r;
      lives_s    = lives_r;
      inv_cnt_s  = inv_cnt_r;
      armed_s    = armed_r;
      level_up_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (bus.Start) begin
               state_s   = S_PLAY;
               level_s   = '0;
               lives_s   = LIVES_W'(LIVES_INIT);
               armed_s   = 1'b0;
               inv_cnt_s = '0;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_PLAY: begin
            if (inv_cnt_r != '0) begin
               inv_cnt_s = inv_cnt_r - INV_W'(1);
            end else begin
               inv_cnt_s = '0;
            end
            // Requiring a low Enemies_Clear first stops a stale clear from
            // the previous level skipping the new one.
            if (!bus.Enemies_Clear) begin
               armed_s = 1'b1;
            end else begin
               armed_s = armed_r;
            end
            if (hit_ok_s) begin
               if (lives_r <= LIVES_W'(1)) begin
                  state_s = S_OVER;
                  lives_s = '0;
               end else begin
                  lives_s   = lives_r - LIVES_W'(1);
                  inv_cnt_s = INV_W'(INVULN_CYCLES);
               end
            end else if (clear_s) begin
               if (last_level_s) begin
                  state_s = S_WIN;
               end else begin
                  level_s    = level_r + LVL_W'(1);
                  level_up_s = 1'b1;
                  armed_s    = 1'b0;
               end
            end else if (bus.Pause) begin
               state_s = S_PAUSE;
            end else begin
               state_s = S_PLAY;
            end
         end
         S_PAUSE: begin
            if (bus.Pause) begin
               state_s = S_PLAY;
            end else begin
               state_s = S_PAUSE;
            end
         end
         S_OVER, S_WIN: begin
            if (bus.Ack) begin
               state_s = S_IDLE;
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r    <= S_IDLE;
         level_r    <= '0;
         lives_r    <= '0;
         inv_cnt_r  <= '0;
         armed_r    <= 1'b0;
         level_up_r <= 1'b0;
         invuln_r   <= 1'b0;
      end else begin
         state_r    <= state_s;
         level_r    <= level_s;
         lives_r    <= lives_s;
         inv_cnt_r  <= inv_cnt_s;
         armed_r    <= armed_s;
         level_up_r <= level_up_s;
         invuln_r   <= (inv_cnt_s != '0);
      end
   end

   // One-hot state flags, registered from the next state so they track state_r.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         q_idle_r  <= 1'b1;
         q_play_r  <= 1'b0;
         q_pause_r <= 1'b0;
         q_over_r  <= 1'b0;
         q_win_r   <= 1'b0;
      end else begin
         q_idle_r  <= (state_s == S_IDLE);
         q_play_r  <= (state_s == S_PLAY);
         q_pause_r <= (state_s == S_PAUSE);
         q_over_r  <= (state_s == S_OVER);
         q_win_r   <= (state_s == S_WIN);
      end
   end

   assign bus.Level      = level_r;
   assign bus.Lives_Left = lives_r;
   assign bus.Level_Up   = level_up_r;
   assign bus.Invuln     = invuln_r;
   assign bus.q_Idle     = q_idle_r;
   assign bus.q_Play     = q_play_r;
   assign bus.q_Pause    = q_pause_r;
   assign bus.q_Over     = q_over_r;
   assign bus.q_Win      = q_win_r;

endmodule

// File: tb/tb_game_level_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_level_ctrl
// Directed bench for game_level_ctrl with default parameters
// (NUM_LEVELS=4, LIVES_INIT=3, KEY_MASK=8'b0000_0100, INVULN_CYCLES=16).
// -----------------------------------------------------------------------------
module tb_game_level_ctrl;

   localparam logic [4:0] F_IDLE  = 5'b10000;
   localparam logic [4:0] F_PLAY  = 5'b01000;
   localparam logic [4:0] F_PAUSE = 5'b00100;
   localparam logic [4:0] F_OVER  = 5'b00010;
   localparam logic [4:0] F_WIN   = 5'b00001;

   logic Clk;
   logic Reset;
   int   passed;
   int   total;

   game_level_if #(.LVL_W(3), .LIVES_W(2)) bus ();

   game_level_ctrl #(
      .NUM_LEVELS   (4),
      .LVL_W        (3),
      .LIVES_INIT   (3),
      .LIVES_W      (2),
      .KEY_MASK     (8'b0000_0100),
      .INVULN_CYCLES(16)
   ) u_dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [4:0] flags();
      return {bus.q_Idle, bus.q_Play, bus.q_Pause, bus.q_Over, bus.q_Win};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      passed = 0;
      total  = 0;
      Reset  = 1'b1;
      bus.Start = 1'b0; bus.Ack = 1'b0; bus.Pause = 1'b0; bus.Hit = 1'b0;
      bus.Enemies_Clear = 1'b0; bus.Key_Held = 1'b0;
      tick(); tick();
      chk("rst_flags", 32'(flags()), 32'(F_IDLE));
      chk("rst_level", 32'(bus.Level), 32'd0);
      chk("rst_lives", 32'(bus.Lives_Left), 32'd0);
      chk("rst_lvlup", 32'(bus.Level_Up), 32'd0);
      chk("rst_invuln", 32'(bus.Invuln), 32'd0);
      Reset = 1'b0;
      tick();
      chk("idle_hold", 32'(flags()), 32'(F_IDLE));

      // Walk all four levels; level 2 needs the key, so hold it here.
      bus.Key_Held = 1'b1;
      bus.Start = 1'b1; tick(); bus.Start = 1'b0;
      chk("start_flags", 32'(flags()), 32'(F_PLAY));
      chk("start_lives", 32'(bus.Lives_Left), 32'd3);
      chk("start_level", 32'(bus.Level), 32'd0);
      // Enemies_Clear high in the first PLAY cycle, not yet armed: no advance.
      bus.Enemies_Clear = 1'b1; tick();
      chk("unarmed_level", 32'(bus.Level), 32'd0);
      for (int i = 0; i < 4; i++) begin
         bus.Enemies_Clear = 1'b0; tick();
         if (i > 0) chk("lvlup_drop", 32'(bus.Level_Up), 32'd0);
         bus.Enemies_Clear = 1'b1; tick();
         if (i < 3) begin
            chk("adv_level", 32'(bus.Level), 32'(i + 1));
            chk("adv_lvlup", 32'(bus.Level_Up), 32'd1);
            chk("adv_flags", 32'(flags()), 32'(F_PLAY));
         end else begin
            chk("win_flags", 32'(flags()), 32'(F_WIN));
            chk("win_level", 32'(bus.Level), 32'd3);
            chk("win_lvlup", 32'(bus.Level_Up), 32'd0);
         end
      end
      bus.Enemies_Clear = 1'b0; bus.Key_Held = 1'b0;
      tick();
      chk("win_wait", 32'(flags()), 32'(F_WIN));
      bus.Ack = 1'b1; tick(); bus.Ack = 1'b0;
      chk("ack_idle", 32'(flags()), 32'(F_IDLE));
      chk("idle_level_held", 32'(bus.Level), 32'd3);

      // Lives and invulnerability window.
      bus.Start = 1'b1; tick(); bus.Start = 1'b0;
      bus.Hit = 1'b1; tick(); bus.Hit = 1'b0;
      chk("hit1_lives", 32'(bus.Lives_Left), 32'd2);
      chk("hit1_invuln", 32'(bus.Invuln), 32'd1);
      repeat (4) tick();
      bus.Hit = 1'b1; tick(); bus.Hit = 1'b0;
      chk("hit_blocked", 32'(bus.Lives_Left), 32'd2);
      repeat (10) tick();
      chk("invuln_last", 32'(bus.Invuln), 32'd1);
      tick();
      chk("invuln_end", 32'(bus.Invuln), 32'd0);
      bus.Hit = 1'b1; tick(); bus.Hit = 1'b0;
      chk("hit2_lives", 32'(bus.Lives_Left), 32'd1);
      repeat (16) tick();
      bus.Hit = 1'b1; tick(); bus.Hit = 1'b0;
      chk("over_flags", 32'(flags()), 32'(F_OVER));
      chk("over_lives", 32'(bus.Lives_Left), 32'd0);
      bus.Hit = 1'b1; bus.Start = 1'b1; tick(); bus.Hit = 1'b0; bus.Start = 1'b0;
      chk("over_ignores", 32'(flags()), 32'(F_OVER));
      bus.Ack = 1'b1; tick(); bus.Ack = 1'b0;
      chk("over_ack", 32'(flags()), 32'(F_IDLE));
      chk("over_lives_held", 32'(bus.Lives_Left), 32'd0);

      // Key requirement on level 2, then stale clear across an advance.
      bus.Start = 1'b1; tick(); bus.Start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.Enemies_Clear = 1'b0; tick();
         bus.Enemies_Clear = 1'b1; tick();
      end
      chk("key_lvl2", 32'(bus.Level), 32'd2);
      bus.Enemies_Clear = 1'b0; tick();
      bus.Enemies_Clear = 1'b1; tick();
      chk("key_missing", 32'(bus.Level), 32'd2);
      tick();
      chk("key_missing2", 32'(bus.Level), 32'd2);
      bus.Key_Held = 1'b1; tick();
      chk("key_level", 32'(bus.Level), 32'd3);
      chk("key_lvlup", 32'(bus.Level_Up), 32'd1);
      bus.Key_Held = 1'b0;
      repeat (3) tick();
      chk("stale_flags", 32'(flags()), 32'(F_PLAY));
      chk("stale_level", 32'(bus.Level), 32'd3);
      bus.Enemies_Clear = 1'b0; tick();
      bus.Enemies_Clear = 1'b1; tick(); bus.Enemies_Clear = 1'b0;
      chk("stale_win", 32'(flags()), 32'(F_WIN));
      bus.Ack = 1'b1; tick(); bus.Ack = 1'b0;

      // Pause freezes invulnerability at 10 and ignores gameplay inputs.
      bus.Start = 1'b1; tick(); bus.Start = 1'b0;
      bus.Hit = 1'b1; tick(); bus.Hit = 1'b0;
      repeat (5) tick();
      bus.Pause = 1'b1; tick(); bus.Pause = 1'b0;
      chk("pause_flags", 32'(flags()), 32'(F_PAUSE));
      for (int i = 0; i < 50; i++) begin
         bus.Hit = (i % 5 == 0) ? 1'b1 : 1'b0;
         bus.Enemies_Clear = (i % 2 == 0) ? 1'b1 : 1'b0;
         bus.Ack = 1'b1;
         tick();
      end
      bus.Hit = 1'b0; bus.Enemies_Clear = 1'b0; bus.Ack = 1'b0;
      chk("pause_lives", 32'(bus.Lives_Left), 32'd2);
      chk("pause_level", 32'(bus.Level), 32'd0);
      chk("pause_hold", 32'(flags()), 32'(F_PAUSE));
      chk("pause_invuln", 32'(bus.Invuln), 32'd1);
      bus.Pause = 1'b1; tick(); bus.Pause = 1'b0;
      chk("resume_flags", 32'(flags()), 32'(F_PLAY));
      repeat (9) tick();
      chk("resume_inv_last", 32'(bus.Invuln), 32'd1);
      tick();
      chk("resume_inv_end", 32'(bus.Invuln), 32'd0);

      // Taken hit beats a valid clear; a blocked hit does not.
      bus.Hit = 1'b1; bus.Enemies_Clear = 1'b1; tick();
      chk("hitclr_lives", 32'(bus.Lives_Left), 32'd1);
      chk("hitclr_level", 32'(bus.Level), 32'd0);
      chk("hitclr_flags", 32'(flags()), 32'(F_PLAY));
      tick(); bus.Hit = 1'b0; bus.Enemies_Clear = 1'b0;
      chk("blkhit_level", 32'(bus.Level), 32'd1);
      chk("blkhit_lives", 32'(bus.Lives_Left), 32'd1);
      chk("blkhit_lvlup", 32'(bus.Level_Up), 32'd1);

      // Asynchronous reset mid-game, checked before any clock edge.
      #2 Reset = 1'b1;
      #1;
      chk("areset_flags", 32'(flags()), 32'(F_IDLE));
      chk("areset_level", 32'(bus.Level), 32'd0);
      chk("areset_lives", 32'(bus.Lives_Left), 32'd0);
      chk("areset_invuln", 32'(bus.Invuln), 32'd0);
      tick();
      Reset = 1'b0;
      tick();
      chk("post_reset", 32'(flags()), 32'(F_IDLE));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
